// File: rtl/riscv_ctrl_pkg.sv
// Shared types for the control pipeline: decoded control bundle, ALUOp and forward-select encodings, opcodes.
// Pure declarations; no latency or flow control of its own.
package riscv_ctrl_pkg;

    typedef struct packed {
        logic       ALUSrc;
        logic       mem2Reg;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       branch;
        logic       jump;
        logic [1:0] ALUOp;
    } ctrl_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b01
    } fwd_sel_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/ctrl_pipeline_if.sv
// Decode-side inputs and per-stage control/hazard/forwarding outputs of the control pipeline.
// slave = the pipeline itself, master = the datapath/testbench side.
interface ctrl_pipeline_if
    import riscv_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) ();

    logic              id_valid;
    logic              id_ALUSrc;
    logic              id_mem2Reg;
    logic              id_regWrite;
    logic              id_memRead;
    logic              id_memWrite;
    logic              id_branch;
    logic              id_jump;
    logic [1:0]        id_ALUOp;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              ex_redirect;

    logic              pc_write_en;
    logic              ifid_write_en;
    logic              ifid_flush;
    ctrl_t             ex_ctrl;
    ctrl_t             mem_ctrl;
    logic              wb_regWrite;
    logic              wb_mem2Reg;
    logic [REG_AW-1:0] ex_rd;
    logic [REG_AW-1:0] mem_rd;
    logic [REG_AW-1:0] wb_rd;
    fwd_sel_e          fwd_a;
    fwd_sel_e          fwd_b;

    modport slave (
        input  id_valid, id_ALUSrc, id_mem2Reg, id_regWrite, id_memRead, id_memWrite,
               id_branch, id_jump, id_ALUOp, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, ex_redirect,
        output pc_write_en, ifid_write_en, ifid_flush, ex_ctrl, mem_ctrl, wb_regWrite,
               wb_mem2Reg, ex_rd, mem_rd, wb_rd, fwd_a, fwd_b
    );

    modport master (
        output id_valid, id_ALUSrc, id_mem2Reg, id_regWrite, id_memRead, id_memWrite,
               id_branch, id_jump, id_ALUOp, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, ex_redirect,
        input  pc_write_en, ifid_write_en, ifid_flush, ex_ctrl, mem_ctrl, wb_regWrite,
               wb_mem2Reg, ex_rd, mem_rd, wb_rd, fwd_a, fwd_b
    );

endinterface

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register {valid, ctrl, rd, rs1, rs2}; 1-cycle latency, no backpressure.
// A bubble request or an invalid input captures an all-zero entry.
module ctrl_stage_reg
    import riscv_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_bubble,
    input  logic              i_valid,
    input  ctrl_t             i_ctrl,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    output logic              o_valid,
    output ctrl_t             o_ctrl,
    output logic [REG_AW-1:0] o_rd,
    output logic [REG_AW-1:0] o_rs1,
    output logic [REG_AW-1:0] o_rs2
);

    logic              r_valid;
    ctrl_t             r_ctrl;
    logic [REG_AW-1:0] r_rd;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_rd    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
        end else if (i_bubble || !i_valid) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_rd    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
        end else begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_rd    <= i_rd;
            r_rs1   <= i_rs1;
            r_rs2   <= i_rs2;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_rd    = r_rd;
    assign o_rs1   = r_rs1;
    assign o_rs2   = r_rs2;

endmodule

// File: rtl/ctrl_pipeline.sv
// Carries decoded control through EX/MEM/WB (1 cycle per stage), stalls on load-use, squashes on redirect,
// and selects EX operand forwarding; hazards hold PC and IF/ID instead of any ready/valid backpressure.
module ctrl_pipeline
    import riscv_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int NSTAGE = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    ctrl_pipeline_if.slave bus
);

    localparam int S_EX  = 0;
    localparam int S_MEM = 1;
    localparam int S_WB  = 2;

    ctrl_t                          w_id_ctrl;
    logic                           w_stall;
    logic                           w_bubble;
    logic [NSTAGE-1:0]              w_valid;
    ctrl_t [NSTAGE-1:0]             w_ctrl;
    logic [NSTAGE-1:0][REG_AW-1:0]  w_rd;
    logic [NSTAGE-1:0][REG_AW-1:0]  w_rs1;
    logic [NSTAGE-1:0][REG_AW-1:0]  w_rs2;
    logic                           w_mem_fwd_ok;
    logic                           w_wb_fwd_ok;
    ctrl_t                          w_mem_ctrl;
    logic                           w_unused;

    always_comb begin
        w_id_ctrl          = '0;
        w_id_ctrl.ALUSrc   = bus.id_ALUSrc;
        w_id_ctrl.mem2Reg  = bus.id_mem2Reg;
        w_id_ctrl.regWrite = bus.id_regWrite;
        w_id_ctrl.memRead  = bus.id_memRead;
        w_id_ctrl.memWrite = bus.id_memWrite;
        w_id_ctrl.branch   = bus.id_branch;
        w_id_ctrl.jump     = bus.id_jump;
        w_id_ctrl.ALUOp    = bus.id_ALUOp;
    end

    // A load in EX whose result ID needs next cycle cannot be forwarded in time; x0 never hazards.
    assign w_stall = bus.id_valid & w_valid[S_EX] & w_ctrl[S_EX].memRead & (w_rd[S_EX] != '0) &
                     ((bus.id_use_rs1 & (bus.id_rs1 == w_rd[S_EX])) |
                      (bus.id_use_rs2 & (bus.id_rs2 == w_rd[S_EX])));

    // Redirect wins: the stalled ID instruction is wrong-path anyway, so the front end keeps moving.
    assign w_bubble          = w_stall | bus.ex_redirect;
    assign bus.pc_write_en   = ~w_stall | bus.ex_redirect;
    assign bus.ifid_write_en = ~w_stall | bus.ex_redirect;
    assign bus.ifid_flush    = bus.ex_redirect;

    for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
        if (g == 0) begin : g_ex
            ctrl_stage_reg #(.REG_AW(REG_AW)) u_reg (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_bubble(w_bubble),
                .i_valid (bus.id_valid),
                .i_ctrl  (w_id_ctrl),
                .i_rd    (bus.id_rd),
                .i_rs1   (bus.id_rs1),
                .i_rs2   (bus.id_rs2),
                .o_valid (w_valid[g]),
                .o_ctrl  (w_ctrl[g]),
                .o_rd    (w_rd[g]),
                .o_rs1   (w_rs1[g]),
                .o_rs2   (w_rs2[g])
            );
        end else begin : g_adv
            ctrl_stage_reg #(.REG_AW(REG_AW)) u_reg (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_bubble(1'b0),
                .i_valid (w_valid[g-1]),
                .i_ctrl  (w_ctrl[g-1]),
                .i_rd    (w_rd[g-1]),
                .i_rs1   (w_rs1[g-1]),
                .i_rs2   (w_rs2[g-1]),
                .o_valid (w_valid[g]),
                .o_ctrl  (w_ctrl[g]),
                .o_rd    (w_rd[g]),
                .o_rs1   (w_rs1[g]),
                .o_rs2   (w_rs2[g])
            );
        end
    end

    function automatic fwd_sel_e fwd_pick(input logic              mem_ok,
                                          input logic [REG_AW-1:0] mem_rd,
                                          input logic              wb_ok,
                                          input logic [REG_AW-1:0] wb_rd,
                                          input logic [REG_AW-1:0] src);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (mem_ok && (mem_rd == src)) begin
            sel = FWD_MEM;
        end else if (wb_ok && (wb_rd == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    assign w_mem_fwd_ok = w_valid[S_MEM] & w_ctrl[S_MEM].regWrite & (w_rd[S_MEM] != '0);
    assign w_wb_fwd_ok  = w_valid[S_WB]  & w_ctrl[S_WB].regWrite  & (w_rd[S_WB]  != '0);

    assign bus.fwd_a = fwd_pick(w_mem_fwd_ok, w_rd[S_MEM], w_wb_fwd_ok, w_rd[S_WB], w_rs1[S_EX]);
    assign bus.fwd_b = fwd_pick(w_mem_fwd_ok, w_rd[S_MEM], w_wb_fwd_ok, w_rd[S_WB], w_rs2[S_EX]);

    always_comb begin
        w_mem_ctrl          = '0;
        w_mem_ctrl.memRead  = w_ctrl[S_MEM].memRead;
        w_mem_ctrl.memWrite = w_ctrl[S_MEM].memWrite;
        w_mem_ctrl.mem2Reg  = w_ctrl[S_MEM].mem2Reg;
        w_mem_ctrl.regWrite = w_ctrl[S_MEM].regWrite;
    end

    assign bus.ex_ctrl     = w_ctrl[S_EX];
    assign bus.mem_ctrl    = w_mem_ctrl;
    assign bus.wb_regWrite = w_valid[S_WB] & w_ctrl[S_WB].regWrite;
    assign bus.wb_mem2Reg  = w_valid[S_WB] & w_ctrl[S_WB].mem2Reg;
    assign bus.ex_rd       = w_rd[S_EX];
    assign bus.mem_rd      = w_rd[S_MEM];
    assign bus.wb_rd       = w_rd[S_WB];

    // Later stages keep the source indices and full bundle only so all stages share one register type.
    assign w_unused = ^{w_ctrl[S_MEM], w_ctrl[S_WB], w_rs1[S_WB:S_MEM], w_rs2[S_WB:S_MEM]};

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: an instruction-level pipeline model checked every cycle,
// plus hand-computed checks for the reset, stream, load-use, forwarding, redirect and x0 cases.
module tb_ctrl_pipeline;
    import riscv_ctrl_pkg::*;

    typedef struct packed {
        logic       v;
        ctrl_t      c;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } minst_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    ctrl_pipeline_if #(.REG_AW(5)) bus ();

    ctrl_pipeline #(.REG_AW(5), .NSTAGE(3)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction currently presented in ID, as the bench sees it.
    logic       cur_v;
    logic [6:0] cur_op;
    logic [4:0] cur_rd, cur_rs1, cur_rs2;
    logic       cur_u1, cur_u2, cur_redir;

    minst_t m_ex, m_mem, m_wb;

    function automatic ctrl_t decode(input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_R:      begin c.regWrite = 1; c.ALUOp = ALUOP_FUNCT; end
            OP_I:      begin c.ALUSrc = 1; c.regWrite = 1; c.ALUOp = ALUOP_FUNCT; end
            OP_LOAD:   begin c.ALUSrc = 1; c.mem2Reg = 1; c.regWrite = 1; c.memRead = 1; c.ALUOp = ALUOP_ADD; end
            OP_STORE:  begin c.ALUSrc = 1; c.memWrite = 1; c.ALUOp = ALUOP_ADD; end
            OP_BRANCH: begin c.branch = 1; c.ALUOp = ALUOP_BR; end
            OP_JAL:    begin c.jump = 1; c.regWrite = 1; end
            OP_JALR:   begin c.jump = 1; c.regWrite = 1; c.ALUSrc = 1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    function automatic logic exp_stall();
        logic hit1, hit2;
        hit1 = cur_u1 && (cur_rs1 == m_ex.rd);
        hit2 = cur_u2 && (cur_rs2 == m_ex.rd);
        return cur_v && m_ex.v && m_ex.c.memRead && (m_ex.rd != 5'd0) && (hit1 || hit2);
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (m_mem.v && m_mem.c.regWrite && m_mem.rd != 5'd0 && m_mem.rd == src) return 2'b10;
        if (m_wb.v && m_wb.c.regWrite && m_wb.rd != 5'd0 && m_wb.rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic ctrl_t mem_view(input ctrl_t c);
        ctrl_t t;
        t          = '0;
        t.memRead  = c.memRead;
        t.memWrite = c.memWrite;
        t.mem2Reg  = c.mem2Reg;
        t.regWrite = c.regWrite;
        return t;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex  = '0;
            m_mem = '0;
            m_wb  = '0;
        end else begin
            logic squash;
            squash = exp_stall() || cur_redir || !cur_v;
            m_wb   = m_mem;
            m_mem  = m_ex;
            if (squash) m_ex = '0;
            else m_ex = '{v: 1'b1, c: decode(cur_op), rd: cur_rd, rs1: cur_rs1, rs2: cur_rs2};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("pc_write_en",   32'(bus.pc_write_en),   32'(cur_redir || !exp_stall()));
        chk("ifid_write_en", 32'(bus.ifid_write_en), 32'(cur_redir || !exp_stall()));
        chk("ifid_flush",    32'(bus.ifid_flush),    32'(cur_redir));
        chk("ex_ctrl",       32'(bus.ex_ctrl),       32'(m_ex.c));
        chk("mem_ctrl",      32'(bus.mem_ctrl),      32'(mem_view(m_mem.c)));
        chk("wb_regWrite",   32'(bus.wb_regWrite),   32'(m_wb.v && m_wb.c.regWrite));
        chk("wb_mem2Reg",    32'(bus.wb_mem2Reg),    32'(m_wb.v && m_wb.c.mem2Reg));
        chk("ex_rd",         32'(bus.ex_rd),         32'(m_ex.rd));
        chk("mem_rd",        32'(bus.mem_rd),        32'(m_mem.rd));
        chk("wb_rd",         32'(bus.wb_rd),         32'(m_wb.rd));
        chk("fwd_a",         32'(bus.fwd_a),         32'(exp_fwd(m_ex.rs1)));
        chk("fwd_b",         32'(bus.fwd_b),         32'(exp_fwd(m_ex.rs2)));
    end

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2);
        ctrl_t c;
        c = v ? decode(op) : '0;
        cur_v = v; cur_op = op; cur_rd = rd; cur_rs1 = rs1; cur_rs2 = rs2; cur_u1 = u1; cur_u2 = u2;
        bus.id_valid    = v;
        bus.id_ALUSrc   = c.ALUSrc;
        bus.id_mem2Reg  = c.mem2Reg;
        bus.id_regWrite = c.regWrite;
        bus.id_memRead  = c.memRead;
        bus.id_memWrite = c.memWrite;
        bus.id_branch   = c.branch;
        bus.id_jump     = c.jump;
        bus.id_ALUOp    = c.ALUOp;
        bus.id_rd       = rd;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_use_rs1  = u1;
        bus.id_use_rs2  = u2;
    endtask

    task automatic redir(input logic r);
        cur_redir       = r;
        bus.ex_redirect = r;
    endtask

    task automatic nop();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        redir(1'b0);
        nop();
        #1;
        chk("rst_pc_we",   32'(bus.pc_write_en),   32'd1);
        chk("rst_ifid_we", 32'(bus.ifid_write_en), 32'd1);
        chk("rst_flush",   32'(bus.ifid_flush),    32'd0);
        chk("rst_ex_ctrl", 32'(bus.ex_ctrl),       32'd0);
        chk("rst_fwd_a",   32'(bus.fwd_a),         32'd0);
        #11 rst_n = 1'b1;
        step();

        // R-type stream: rd=5
        drive(1'b1, OP_R, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1);
        step();
        chk("r_ex_regwrite", 32'(bus.ex_ctrl.regWrite), 32'd1);
        chk("r_ex_rd",       32'(bus.ex_rd),            32'd5);
        nop();
        step();
        step();
        chk("r_wb_regwrite", 32'(bus.wb_regWrite), 32'd1);
        chk("r_wb_rd",       32'(bus.wb_rd),       32'd5);

        // Load x6 then add using x6: one stall cycle, then forward from WB
        drive(1'b1, OP_LOAD, 5'd6, 5'd1, 5'd0, 1'b1, 1'b0);
        step();
        drive(1'b1, OP_R, 5'd8, 5'd6, 5'd3, 1'b1, 1'b1);
        #1;
        chk("lu_pc_we_0",   32'(bus.pc_write_en),   32'd0);
        chk("lu_ifid_we_0", 32'(bus.ifid_write_en), 32'd0);
        step();
        chk("lu_bubble",    32'(bus.ex_ctrl),     32'd0);
        chk("lu_pc_we_1",   32'(bus.pc_write_en), 32'd1);
        step();
        chk("lu_fwd_a",     32'(bus.fwd_a), 32'b01);
        chk("lu_fwd_b",     32'(bus.fwd_b), 32'b00);
        chk("lu_ex_rd",     32'(bus.ex_rd), 32'd8);

        // Back-to-back x7 producer/consumer -> MEM forward
        drive(1'b1, OP_R, 5'd7, 5'd1, 5'd2, 1'b1, 1'b1);
        step();
        drive(1'b1, OP_R, 5'd9, 5'd4, 5'd7, 1'b1, 1'b1);
        #1;
        chk("b2b_no_stall", 32'(bus.pc_write_en), 32'd1);
        step();
        chk("b2b_fwd_b", 32'(bus.fwd_b), 32'b10);
        chk("b2b_fwd_a", 32'(bus.fwd_a), 32'b00);

        // One instruction between -> WB forward
        drive(1'b1, OP_R, 5'd7, 5'd1, 5'd2, 1'b1, 1'b1);
        step();
        drive(1'b1, OP_I, 5'd10, 5'd1, 5'd0, 1'b1, 1'b0);
        step();
        drive(1'b1, OP_R, 5'd9, 5'd4, 5'd7, 1'b1, 1'b1);
        step();
        chk("gap_fwd_b", 32'(bus.fwd_b), 32'b01);

        // Both MEM and WB write x7: MEM is younger and wins
        drive(1'b1, OP_R, 5'd7, 5'd1, 5'd2, 1'b1, 1'b1);
        step();
        drive(1'b1, OP_JAL, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, OP_STORE, 5'd0, 5'd4, 5'd7, 1'b1, 1'b1);
        step();
        chk("both_fwd_b", 32'(bus.fwd_b), 32'b10);

        // Redirect together with a load-use stall
        drive(1'b1, OP_LOAD, 5'd11, 5'd1, 5'd0, 1'b1, 1'b0);
        step();
        drive(1'b1, OP_R, 5'd12, 5'd11, 5'd0, 1'b1, 1'b0);
        redir(1'b1);
        #1;
        chk("rd_flush",   32'(bus.ifid_flush),    32'd1);
        chk("rd_pc_we",   32'(bus.pc_write_en),   32'd1);
        chk("rd_ifid_we", 32'(bus.ifid_write_en), 32'd1);
        step();
        redir(1'b0);
        nop();
        chk("rd_ex_ctrl",   32'(bus.ex_ctrl),          32'd0);
        chk("rd_ex_rd",     32'(bus.ex_rd),            32'd0);
        chk("rd_mem_load",  32'(bus.mem_ctrl.memRead), 32'd1);
        chk("rd_mem_rd",    32'(bus.mem_rd),           32'd11);

        // Writes to x0, then a read of x0
        drive(1'b1, OP_R, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1);
        step();
        drive(1'b1, OP_LOAD, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0);
        step();
        drive(1'b1, OP_R, 5'd13, 5'd0, 5'd0, 1'b1, 1'b1);
        #1;
        chk("x0_no_stall", 32'(bus.pc_write_en), 32'd1);
        step();
        chk("x0_fwd_a", 32'(bus.fwd_a), 32'b00);
        chk("x0_fwd_b", 32'(bus.fwd_b), 32'b00);

        // Illegal opcode flows as a NOP
        drive(1'b1, 7'b0100101, 5'd12, 5'd1, 5'd2, 1'b0, 1'b0);
        step();
        chk("ill_ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
        nop();
        step();
        step();
        chk("ill_wb_regwrite", 32'(bus.wb_regWrite), 32'd0);
        chk("ill_wb_rd",       32'(bus.wb_rd),       32'd12);

        // Reset mid-stream with a load-use pending
        drive(1'b1, OP_R, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1);
        step();
        drive(1'b1, OP_LOAD, 5'd6, 5'd1, 5'd0, 1'b1, 1'b0);
        step();
        drive(1'b1, OP_R, 5'd8, 5'd6, 5'd5, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_ex_ctrl",  32'(bus.ex_ctrl),       32'd0);
        chk("mrst_mem_ctrl", 32'(bus.mem_ctrl),      32'd0);
        chk("mrst_ex_rd",    32'(bus.ex_rd),         32'd0);
        chk("mrst_mem_rd",   32'(bus.mem_rd),        32'd0);
        chk("mrst_wb_rd",    32'(bus.wb_rd),         32'd0);
        chk("mrst_wb_rw",    32'(bus.wb_regWrite),   32'd0);
        chk("mrst_pc_we",    32'(bus.pc_write_en),   32'd1);
        chk("mrst_ifid_we",  32'(bus.ifid_write_en), 32'd1);
        chk("mrst_fwd_a",    32'(bus.fwd_a),         32'd0);
        nop();
        step();
        rst_n = 1'b1;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
